// File: rtl/leaderboard_if.sv
// Submission handshake between the timing core and the leaderboard:
// request/time/clear toward the board, and busy/done/rank back.
interface leaderboard_if #(
    parameter int TW = 39
);
    logic          record;
    logic          mode;
    logic [TW-1:0] new_time;
    logic          clear;
    logic          busy;
    logic          done;
    logic [1:0]    rank;

    modport master (
        output record, mode, new_time, clear,
        input  busy, done, rank
    );

    modport slave (
        input  record, mode, new_time, clear,
        output busy, done, rank
    );
endinterface

// File: rtl/leaderboard.sv
// Two ranked top-three boards (count-up ascending, count-down descending).
// A submission scans one slot per cycle, then commits the whole board in one edge.
module leaderboard #(
    parameter int TW = 39
) (
    input  logic          clk,
    input  logic          rst_n,
    leaderboard_if.slave  lb,
    output logic [TW-1:0] up_time1,
    output logic [TW-1:0] up_time2,
    output logic [TW-1:0] up_time3,
    output logic [TW-1:0] down_time1,
    output logic [TW-1:0] down_time2,
    output logic [TW-1:0] down_time3,
    output logic [2:0]    up_valid,
    output logic [2:0]    down_valid
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic          busy;

    logic [TW-1:0] up_slot_reg   [3];
    logic [TW-1:0] down_slot_reg [3];
    logic [2:0]    up_valid_reg;
    logic [2:0]    down_valid_reg;

    logic [TW-1:0] time_reg;
    logic          mode_reg;
    logic [1:0]    idx_reg;
    logic [1:0]    pos_reg;
    logic          found_reg;
    logic [1:0]    rank_reg;
    logic          done_reg;

    logic [TW-1:0] cur_slot  [3];
    logic [2:0]    cur_valid;
    logic [TW-1:0] ins_slot  [3];
    logic [2:0]    ins_valid;
    logic [TW-1:0] scan_slot;
    logic          scan_valid;
    logic          scan_hit;

    // Candidate board: selected board with the latched time placed at pos_reg
    // and everything from pos_reg downward shifted one slot (old slot 3 drops).
    assign cur_valid = mode_reg ? up_valid_reg : down_valid_reg;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            localparam logic [1:0] SLOT = 2'(gi + 1);

            assign cur_slot[gi] = mode_reg ? up_slot_reg[gi] : down_slot_reg[gi];

            if (gi == 0) begin : g_head
                assign ins_slot[gi]  = (pos_reg == SLOT) ? time_reg : cur_slot[gi];
                assign ins_valid[gi] = (pos_reg == SLOT) ? 1'b1     : cur_valid[gi];
            end else begin : g_tail
                assign ins_slot[gi]  = (SLOT < pos_reg)  ? cur_slot[gi]  :
                                       (SLOT == pos_reg) ? time_reg      :
                                                           cur_slot[gi-1];
                assign ins_valid[gi] = (SLOT < pos_reg)  ? cur_valid[gi] :
                                       (SLOT == pos_reg) ? 1'b1          :
                                                           cur_valid[gi-1];
            end
        end
    endgenerate

    // A slot yields to the new time if it is empty or strictly worse; equal
    // entries keep their place so ties stay stable.
    always_comb begin
        scan_slot  = cur_slot[0];
        scan_valid = cur_valid[0];
        case (idx_reg)
            2'd2: begin
                scan_slot  = cur_slot[1];
                scan_valid = cur_valid[1];
            end
            2'd3: begin
                scan_slot  = cur_slot[2];
                scan_valid = cur_valid[2];
            end
            default: ;
        endcase
        scan_hit = !scan_valid ||
                   (mode_reg ? (time_reg < scan_slot) : (time_reg > scan_slot));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (lb.record) state_next = SCAN;
            SCAN:    if (idx_reg == 2'd3) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (lb.clear) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy = (state_reg != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || lb.clear) begin
            for (int k = 0; k < 3; k++) begin
                up_slot_reg[k]   <= '0;
                down_slot_reg[k] <= '0;
            end
            up_valid_reg   <= '0;
            down_valid_reg <= '0;
            time_reg       <= '0;
            mode_reg       <= 1'b0;
            idx_reg        <= '0;
            pos_reg        <= '0;
            found_reg      <= 1'b0;
            rank_reg       <= '0;
            done_reg       <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (lb.record) begin
                        time_reg  <= lb.new_time;
                        mode_reg  <= lb.mode;
                        idx_reg   <= 2'd1;
                        pos_reg   <= 2'd0;
                        found_reg <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!found_reg && scan_hit) begin
                        pos_reg   <= idx_reg;
                        found_reg <= 1'b1;
                    end
                    idx_reg <= idx_reg + 2'd1;
                end
                WRITE: begin
                    rank_reg <= found_reg ? pos_reg : 2'd0;
                    done_reg <= 1'b1;
                    if (found_reg) begin
                        if (mode_reg) begin
                            for (int k = 0; k < 3; k++) up_slot_reg[k] <= ins_slot[k];
                            up_valid_reg <= ins_valid;
                        end else begin
                            for (int k = 0; k < 3; k++) down_slot_reg[k] <= ins_slot[k];
                            down_valid_reg <= ins_valid;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign lb.busy    = busy;
    assign lb.done    = done_reg;
    assign lb.rank    = rank_reg;

    assign up_time1   = up_slot_reg[0];
    assign up_time2   = up_slot_reg[1];
    assign up_time3   = up_slot_reg[2];
    assign down_time1 = down_slot_reg[0];
    assign down_time2 = down_slot_reg[1];
    assign down_time3 = down_slot_reg[2];
    assign up_valid   = up_valid_reg;
    assign down_valid = down_valid_reg;
endmodule
